// File: rtl/mode1_max_seq_pkg.sv
// Shared definitions for the softmax stage-1 max reducer: FP16 constants,
// lane/counter widths and the FSM encoding.
package mode_defs;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;
  localparam int CNT_WIDTH = 8;

  localparam logic [DATAWIDTH-1:0] FP_NEG_INF   = 16'hFC00;
  localparam logic [DATAWIDTH-1:0] FP_CANON_NAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fp16_is_nan(input logic [DATAWIDTH-1:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/mode1_max_seq_if.sv
// Handshake bundle between the score read-out, the max reducer and the
// subtract stage. slave is the reducer's view, master the driver's view.
interface mode1_max_seq_if;
  import mode_defs::*;

  logic                 start;
  logic [CNT_WIDTH-1:0] num_beats;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a_inp0;
  logic [DATAWIDTH-1:0] a_inp1;
  logic [DATAWIDTH-1:0] a_inp2;
  logic [DATAWIDTH-1:0] a_inp3;
  logic [DATAWIDTH-1:0] max_out;
  logic                 max_valid;
  logic                 max_ready;
  logic                 busy;
  logic                 nan_flag;

  modport slave (
    input  start, num_beats, in_valid, a_inp0, a_inp1, a_inp2, a_inp3, max_ready,
    output in_ready, max_out, max_valid, busy, nan_flag
  );

  modport master (
    output start, num_beats, in_valid, a_inp0, a_inp1, a_inp2, a_inp3, max_ready,
    input  in_ready, max_out, max_valid, busy, nan_flag
  );

endinterface

// File: rtl/mode1_max_seq_fp16_max2.sv
// Two-input FP16 maximum. 'a' is the earlier operand and wins ties; any NaN
// input yields the canonical quiet NaN.
module fp16_max2
  import mode_defs::*;
(
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] z,
  output logic                 is_nan
);

  logic b_gt;

  always_comb begin
    b_gt   = 1'b0;
    is_nan = fp16_is_nan(a) || fp16_is_nan(b);
    // Sign-magnitude order: this also places +0 above -0 without a special case.
    if (a[15] != b[15]) begin
      b_gt = ~b[15];
    end else if (!a[15]) begin
      b_gt = (b[14:0] > a[14:0]);
    end else begin
      b_gt = (b[14:0] < a[14:0]);
    end
    z = is_nan ? FP_CANON_NAN : (b_gt ? b : a);
  end

endmodule

// File: rtl/mode1_max_seq.sv
// Softmax stage 1: reduces a stream of 4-lane FP16 beats to one maximum and
// presents it on a valid/ready result port for the subtract stage.
module mode1_max_seq
  import mode_defs::*;
(
  input  logic            clk,
  input  logic            rst,
  mode1_max_seq_if.slave  bus
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] beats_q, beats_d;
  logic [DATAWIDTH-1:0] max_q,   max_d;
  logic                 nan_q,   nan_d;

  logic [DATAWIDTH-1:0] lane     [NUM];
  logic [DATAWIDTH-1:0] pair_z   [NUM/2];
  logic                 pair_nan [NUM/2];
  logic [DATAWIDTH-1:0] beat_z,   run_z;
  logic                 beat_nan, run_nan;
  logic                 xfer;

  assign lane[0] = bus.a_inp0;
  assign lane[1] = bus.a_inp1;
  assign lane[2] = bus.a_inp2;
  assign lane[3] = bus.a_inp3;

  generate
    for (genvar gi = 0; gi < NUM/2; gi++) begin : g_pair
      fp16_max2 u_pair (
        .a      (lane[2*gi]),
        .b      (lane[2*gi+1]),
        .z      (pair_z[gi]),
        .is_nan (pair_nan[gi])
      );
    end
  endgenerate

  fp16_max2 u_beat (
    .a      (pair_z[0]),
    .b      (pair_z[1]),
    .z      (beat_z),
    .is_nan (beat_nan)
  );

  // Running max goes on 'a' so an equal beat value never replaces it.
  fp16_max2 u_run (
    .a      (max_q),
    .b      (beat_z),
    .z      (run_z),
    .is_nan (run_nan)
  );

  assign xfer = (state_q == ACCUM) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    beats_d = beats_q;
    max_d   = max_q;
    nan_d   = nan_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          beats_d = bus.num_beats;
          max_d   = FP_NEG_INF;
          nan_d   = 1'b0;
          count_d = '0;
          state_d = (bus.num_beats == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          max_d   = run_z;
          nan_d   = nan_q | pair_nan[0] | pair_nan[1] | beat_nan | run_nan;
          count_d = count_q + CNT_WIDTH'(1);
          if (count_q == beats_q - CNT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.max_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      beats_q <= '0;
      max_q   <= FP_NEG_INF;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      beats_q <= beats_d;
      max_q   <= max_d;
      nan_q   <= nan_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.max_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.max_out   = max_q;
  assign bus.nan_flag  = nan_q;

endmodule

// File: tb/tb_mode1_max_seq.sv
// Directed bench for mode1_max_seq: hand-computed FP16 maxima, handshake
// timing, NaN stickiness, backpressure and asynchronous reset.
module tb_mode1_max_seq;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;

  mode1_max_seq_if bus_if ();

  mode1_max_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start_vec(input logic [7:0] n);
    bus_if.start     = 1'b1;
    bus_if.num_beats = n;
    tick();
    bus_if.start     = 1'b0;
  endtask

  task automatic set_lanes(input logic [15:0] l0, l1, l2, l3);
    bus_if.a_inp0 = l0;
    bus_if.a_inp1 = l1;
    bus_if.a_inp2 = l2;
    bus_if.a_inp3 = l3;
  endtask

  task automatic send_beat(input logic [15:0] l0, l1, l2, l3);
    set_lanes(l0, l1, l2, l3);
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic release_result();
    bus_if.max_ready = 1'b1;
    tick();
    bus_if.max_ready = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst       = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.num_beats = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.max_ready = 1'b0;
    set_lanes(16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    tick();
    check("rst_max_out",   bus_if.max_out,   16'hFC00);
    check("rst_max_valid", {15'd0, bus_if.max_valid}, 16'd0);
    check("rst_in_ready",  {15'd0, bus_if.in_ready},  16'd0);
    check("rst_busy",      {15'd0, bus_if.busy},      16'd0);
    check("rst_nan",       {15'd0, bus_if.nan_flag},  16'd0);
    rst = 1'b1;
    tick();

    // Basic two-beat vector.
    start_vec(8'd2);
    check("basic_in_ready", {15'd0, bus_if.in_ready}, 16'd1);
    check("basic_busy",     {15'd0, bus_if.busy},     16'd1);
    send_beat(16'h3C00, 16'hBC00, 16'h3800, 16'hC000);
    check("basic_run0", bus_if.max_out, 16'h3C00);
    set_lanes(16'h4000, 16'h3800, 16'h4200, 16'hBC00);
    bus_if.in_valid = 1'b1;
    #1;
    check("basic_valid_before", {15'd0, bus_if.max_valid}, 16'd0);
    tick();
    bus_if.in_valid = 1'b0;
    check("basic_valid_after", {15'd0, bus_if.max_valid}, 16'd1);
    check("basic_max",         bus_if.max_out,  16'h4200);
    check("basic_nan",         {15'd0, bus_if.nan_flag}, 16'd0);
    check("basic_in_ready_done", {15'd0, bus_if.in_ready}, 16'd0);
    release_result();
    check("basic_idle_valid", {15'd0, bus_if.max_valid}, 16'd0);

    // All negative lanes.
    start_vec(8'd1);
    send_beat(16'hBC00, 16'hC000, 16'hC400, 16'hBC00);
    check("neg_max", bus_if.max_out, 16'hBC00);
    release_result();

    // Signed zeros.
    start_vec(8'd1);
    send_beat(16'h8000, 16'h0000, 16'h8000, 16'h8000);
    check("zero_max", bus_if.max_out, 16'h0000);
    release_result();

    // NaN on lane 2 of beat 1.
    start_vec(8'd3);
    send_beat(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00);
    check("nan_run0", bus_if.max_out, 16'h7C00);
    check("nan_flag0", {15'd0, bus_if.nan_flag}, 16'd0);
    send_beat(16'h7C00, 16'h7C00, 16'h7C01, 16'h7C00);
    check("nan_flag1", {15'd0, bus_if.nan_flag}, 16'd1);
    send_beat(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00);
    check("nan_max",   bus_if.max_out, 16'h7E00);
    check("nan_valid", {15'd0, bus_if.max_valid}, 16'd1);
    release_result();
    check("nan_sticky_idle", {15'd0, bus_if.nan_flag}, 16'd1);

    // Clean vector after NaN, with denormals compared by raw bits.
    start_vec(8'd1);
    check("clean_nan_cleared", {15'd0, bus_if.nan_flag}, 16'd0);
    send_beat(16'h0001, 16'h8001, 16'h0400, 16'h03FF);
    check("clean_max", bus_if.max_out, 16'h0400);
    check("clean_nan", {15'd0, bus_if.nan_flag}, 16'd0);
    release_result();

    // Backpressure: input gaps, num_beats changed mid-vector, stalled result.
    start_vec(8'd2);
    bus_if.num_beats = 8'd1;
    send_beat(16'h3C00, 16'h4400, 16'h0000, 16'h8000);
    check("bp_after_beat0", {15'd0, bus_if.max_valid}, 16'd0);
    set_lanes(16'h7C01, 16'h7C01, 16'h7C01, 16'h7C01);
    tick();
    check("bp_gap_ready", {15'd0, bus_if.in_ready}, 16'd1);
    check("bp_gap_nan",   {15'd0, bus_if.nan_flag}, 16'd0);
    check("bp_gap_max",   bus_if.max_out, 16'h4400);
    send_beat(16'hC400, 16'h4000, 16'h4500, 16'h3800);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", {15'd0, bus_if.max_valid}, 16'd1);
      check("bp_hold_max",   bus_if.max_out, 16'h4500);
      if (i == 1) begin
        bus_if.start     = 1'b1;
        bus_if.num_beats = 8'd0;
      end
      tick();
      bus_if.start = 1'b0;
    end
    check("bp_ignored_start", bus_if.max_out, 16'h4500);
    release_result();
    check("bp_idle_valid", {15'd0, bus_if.max_valid}, 16'd0);
    check("bp_idle_busy",  {15'd0, bus_if.busy},      16'd0);
    tick();
    check("bp_no_queue_busy", {15'd0, bus_if.busy}, 16'd0);
    check("bp_kept_max",      bus_if.max_out, 16'h4500);

    // Zero-length vector.
    start_vec(8'd0);
    check("zero_len_valid", {15'd0, bus_if.max_valid}, 16'd1);
    check("zero_len_max",   bus_if.max_out, 16'hFC00);
    release_result();

    // Asynchronous reset mid-ACCUM.
    start_vec(8'd4);
    send_beat(16'h7C01, 16'h3C00, 16'h3C00, 16'h3C00);
    check("arst_pre_nan", {15'd0, bus_if.nan_flag}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_max",      bus_if.max_out, 16'hFC00);
    check("arst_valid",    {15'd0, bus_if.max_valid}, 16'd0);
    check("arst_in_ready", {15'd0, bus_if.in_ready},  16'd0);
    check("arst_busy",     {15'd0, bus_if.busy},      16'd0);
    check("arst_nan",      {15'd0, bus_if.nan_flag},  16'd0);
    tick();
    rst = 1'b1;
    tick();

    start_vec(8'd1);
    send_beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    check("post_rst_valid", {15'd0, bus_if.max_valid}, 16'd1);
    check("post_rst_max",   bus_if.max_out, 16'h3C00);
    release_result();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
